// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FSM state type and pointer helpers
// for the FIFO read-side controller and its write-side peer.
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  // Pointers are zero-extended into 32 bits; the caller keeps
  // only the low ADDR_W+1 bits, which gives the modular distance.
  function automatic logic [31:0] ptr_diff(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return a - b;
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// fifo_ptr_cnt: wrap-bit pointer counter with sync reset,
// shared by the read and write sides of the FIFO.
module fifo_ptr_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (en)
      ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read side of a same-clock FIFO, either
// standard (one-cycle read latency) or first-word-fall-through.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wptr,
  input  logic              rd,
  input  logic              clr_underflow,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W:0]   rptr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              underflow
);

  localparam logic [ADDR_W:0] AE = AE_LEVEL[ADDR_W:0];

  logic              ram_empty;
  logic [ADDR_W:0]   ram_level;
  logic [31:0]       diff;
  logic              unused_diff;
  logic              re_n;
  logic              bypass;
  logic [DATA_W-1:0] hold;

  fifo_ptr_cnt #(
    .W   (ADDR_W + 1)
  ) u_rptr (
    .clk (clk),
    .rst (rst),
    .en  (ram_re),
    .ptr (rptr)
  );

  assign ram_raddr   = rptr[ADDR_W-1:0];
  assign ram_empty   = (wptr == rptr);
  assign diff        = ptr_diff(32'(wptr), 32'(rptr));
  assign ram_level   = diff[ADDR_W:0];
  assign unused_diff = ^diff[31:ADDR_W+1];

  assign ram_re = re_n & ~rst;

  // RAM data is live only on the cycle after a read; afterwards
  // the captured copy keeps dout steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      bypass <= 1'b0;
      hold   <= '0;
    end else begin
      bypass <= ram_re;
      if (bypass)
        hold <= ram_rdata;
    end
  end

  assign dout = bypass ? ram_rdata : hold;

  generate
    if (FWFT != 0) begin : g_fwft
      state_t state;

      always_comb begin
        re_n = 1'b0;
        if (state == IDLE)
          re_n = ~ram_empty;
        else
          re_n = rd & ~ram_empty;
      end

      always_ff @(posedge clk) begin
        if (rst)
          state <= IDLE;
        else if (state == IDLE) begin
          if (~ram_empty)
            state <= VALID;
        end else begin
          if (rd & ram_empty)
            state <= IDLE;
        end
      end

      assign dout_valid = (state == VALID);
      assign empty      = ~dout_valid;
      assign level      = ram_level
                        + (ADDR_W+1)'(dout_valid);
    end else begin : g_std
      assign re_n       = rd & ~ram_empty;
      assign dout_valid = bypass;
      assign empty      = ram_empty;
      assign level      = ram_level;
    end
  endgenerate

  assign almost_empty = (level <= AE);

  // A fresh underflow outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)
      underflow <= 1'b0;
    else if (rd & empty)
      underflow <= 1'b1;
    else if (clr_underflow)
      underflow <= 1'b0;
  end

endmodule

// File: doc/fifo_read_ctrl.md
FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width (depth 2^ADDR_W).
REQ-002 Parameter DATA_W, default 16, word width.
REQ-003 Parameter AE_LEVEL, default 2, almost-empty threshold in words.
REQ-004 Parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 wptr  in  ADDR_W+1  write pointer from the same-clock write side, including wrap bit.
REQ-009 rd  in  1  read request (standard) or pop/ready (FWFT).
REQ-010 clr_underflow  in  1  clears the sticky underflow flag.
REQ-011 ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_re.
REQ-012 ram_re  out  1  RAM read enable.
REQ-013 ram_raddr  out  ADDR_W  RAM read address, always rptr[ADDR_W-1:0].
REQ-014 rptr  out  ADDR_W+1  read pointer, including wrap bit.
REQ-015 dout  out  DATA_W  read data.
REQ-016 dout_valid  out  1  dout holds a valid word.
REQ-017 empty  out  1  no word available to the reader.
REQ-018 almost_empty  out  1  level <= AE_LEVEL.
REQ-019 level  out  ADDR_W+1  words available to the reader.
REQ-020 underflow  out  1  sticky; set by a read attempt while empty.

Function
REQ-021 ram_empty = (wptr == rptr); ram_level = (wptr - rptr) modulo 2^(ADDR_W+1); full pointer-width arithmetic; wrap 2^(ADDR_W+1)-1 -> 0.
REQ-022 rptr increments by 1 exactly on cycles with ram_re=1; otherwise holds.
REQ-023 FWFT=0: ram_re = rd & ~ram_empty; dout loads ram_rdata and dout_valid=1 on the cycle after ram_re; otherwise dout_valid=0 and dout holds; empty = ram_empty; level = ram_level.
REQ-024 FWFT=1: FSM states IDLE (no word presented) and VALID (word presented); dout_valid = (state == VALID).
REQ-025 IDLE: if ~ram_empty then ram_re=1, next state VALID; else stay IDLE; rd is ignored for data.
REQ-026 VALID & ~rd: ram_re=0, dout holds, stay VALID.
REQ-027 VALID & rd & ~ram_empty: ram_re=1, stay VALID; the next word is presented the following cycle with no bubble.
REQ-028 VALID & rd & ram_empty: ram_re=0, next state IDLE.
REQ-029 FWFT=1 dout: bypass flag set on the cycle after any ram_re; while set, dout = ram_rdata and ram_rdata is captured into a hold register; while clear, dout = hold register. dout stays stable while dout_valid & ~rd.
REQ-030 FWFT=1: empty = ~dout_valid; level = ram_level + dout_valid.
REQ-031 underflow sets on any cycle with rd & empty; clr_underflow clears it; simultaneous set and clear: set wins.
REQ-032 ram_re is never asserted when ram_empty=1 or rst=1.

Reset
REQ-033 On rst=1 at a clock edge: rptr=0, state=IDLE, bypass=0, hold=0, dout=0, dout_valid=0, underflow=0; ram_re=0 combinationally while rst=1.
REQ-034 Reset mid-operation discards any in-flight read and presented word; the write side is reset by the same rst, so wptr=0 and empty=1 on the first post-reset cycle.

Structure
REQ-035 Shared package fifo_pkg holds the FSM state enum (IDLE, VALID) and the pointer-difference function used for level.
REQ-036 One sub-module fifo_ptr_cnt: ADDR_W+1-bit pointer with sync reset and increment enable, reused by the write side.

Verification (ADDR_W=4, DATA_W=16, AE_LEVEL=2)
REQ-037 FWFT=0: write 0x0001..0x0003, rd held 3 cycles -> ram_re 3 cycles, dout 0x0001/0x0002/0x0003 with dout_valid on the cycle after each, rptr=3, empty=1.
REQ-038 FWFT=1: write 0x00A5 with rd=0 -> dout_valid=1 and dout=0x00A5 one cycle after ram_re; level=1, empty=0, almost_empty=1.
REQ-039 FWFT=1: 16 words queued, rd held high -> one word per cycle, no dout_valid gap, 16 words in order, then IDLE and empty=1.
REQ-040 Wrap: rptr=31, one word queued and read -> rptr=0, ram_raddr=0, level=0.
REQ-041 rd=1 while empty -> no ram_re, rptr unchanged, underflow=1; clr_underflow with a new underflow on the same cycle -> underflow stays 1.
REQ-042 rst asserted in VALID with 5 words queued -> next cycle rptr=0, dout_valid=0, dout=0, underflow=0, ram_re=0.
